// File: rtl/pcpi_mul_ctrl_pkg.sv
// rtl/pcpi_mul_ctrl_pkg.sv - RV32M multiply decode constants, FSM states and operand helpers
package pcpi_mul_ctrl_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;
    localparam logic [1:0] F3_MUL     = 2'b00;
    localparam logic [1:0] F3_MULH    = 2'b01;
    localparam logic [1:0] F3_MULHSU  = 2'b10;
    localparam logic [1:0] F3_MULHU   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MULT,
        ST_FIX,
        ST_DONE
    } state_t;

    // funct3[2]==1 selects DIV/REM, which this block leaves to another unit
    function automatic logic is_mul(input logic [31:0] insn);
        return (insn[6:0] == OPC_OP) && (insn[31:25] == F7_MULDIV) && !insn[14];
    endfunction

    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/arr_multiplier_32b.sv
// rtl/arr_multiplier_32b.sv - combinational 32x32->64 unsigned array multiplier
module arr_multiplier_32b (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] p
);

    // clk/resetn are kept on the port list so the instance matches the existing array
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ resetn;

    assign p = {32'd0, a} * {32'd0, b};

endmodule

// File: rtl/pcpi_mul_ctrl.sv
// rtl/pcpi_mul_ctrl.sv - PCPI sequencer wrapping the array multiplier for MUL/MULH/MULHSU/MULHU
module pcpi_mul_ctrl
    import pcpi_mul_ctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MULT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            pcpi_valid,
    input  logic [31:0]     pcpi_insn,
    input  logic [XLEN-1:0] pcpi_rs1,
    input  logic [XLEN-1:0] pcpi_rs2,
    output logic            pcpi_wr,
    output logic [XLEN-1:0] pcpi_rd,
    output logic            pcpi_wait,
    output logic            pcpi_ready
);

    localparam int CW = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;

    state_t            state_q, state_d;
    logic              done_q;
    logic [1:0]        f3_q;
    logic [XLEN-1:0]   rs1_q, rs2_q, a_q, b_q;
    logic              neg_q;
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN-1:0] arr_p, prod_q, res;
    logic              abort, s1, s2;

    logic unused_insn;
    assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

    arr_multiplier_32b u_arr (
        .clk    (clk),
        .resetn (resetn),
        .a      (a_q),
        .b      (b_q),
        .p      (arr_p)
    );

    assign s1    = (f3_q != F3_MULHU);
    assign s2    = (f3_q == F3_MUL) || (f3_q == F3_MULH);
    assign abort = !pcpi_valid;
    assign res   = neg_q ? (~prod_q + 64'd1) : prod_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pcpi_valid && is_mul(pcpi_insn) && !done_q) state_d = ST_LOAD;
            ST_LOAD: state_d = abort ? ST_IDLE : ST_MULT;
            ST_MULT: begin
                if (abort)              state_d = ST_IDLE;
                else if (cnt_q == '0)   state_d = ST_FIX;
            end
            ST_FIX:  state_d = abort ? ST_IDLE : ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            done_q     <= 1'b0;
            f3_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            neg_q      <= 1'b0;
            cnt_q      <= '0;
            prod_q     <= '0;
            pcpi_rd    <= '0;
            pcpi_wr    <= 1'b0;
            pcpi_ready <= 1'b0;
            pcpi_wait  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pcpi_wr    <= 1'b0;
            pcpi_ready <= 1'b0;
            pcpi_wait  <= (state_d == ST_MULT) || (state_d == ST_FIX) || (state_d == ST_DONE);
            // Stays set until valid drops, so a CPU slow to release valid never re-issues
            if (!pcpi_valid)
                done_q <= 1'b0;
            else if (state_q == ST_DONE)
                done_q <= 1'b1;
            case (state_q)
                ST_IDLE: if (state_d == ST_LOAD) begin
                    f3_q  <= pcpi_insn[13:12];
                    rs1_q <= pcpi_rs1;
                    rs2_q <= pcpi_rs2;
                end
                ST_LOAD: begin
                    a_q   <= magnitude(rs1_q, s1);
                    b_q   <= magnitude(rs2_q, s2);
                    neg_q <= (s1 & rs1_q[XLEN-1]) ^ (s2 & rs2_q[XLEN-1]);
                    cnt_q <= CW'(MULT_CYCLES - 1);
                end
                ST_MULT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) prod_q <= arr_p;
                end
                ST_FIX:  pcpi_rd <= (f3_q == F3_MUL) ? res[XLEN-1:0] : res[2*XLEN-1:XLEN];
                ST_DONE: begin
                    pcpi_ready <= 1'b1;
                    pcpi_wr    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pcpi_mul_ctrl.sv
// tb/tb_pcpi_mul_ctrl.sv - scoreboard bench for the PCPI multiply sequencer
module tb_pcpi_mul_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
    logic        pcpi_wr, pcpi_wait, pcpi_ready;
    logic [31:0] pcpi_rd;

    int tests = 0;
    int fails = 0;
    logic [31:0] sb[$];

    pcpi_mul_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .pcpi_valid (pcpi_valid),
        .pcpi_insn  (pcpi_insn),
        .pcpi_rs1   (pcpi_rs1),
        .pcpi_rs2   (pcpi_rs2),
        .pcpi_wr    (pcpi_wr),
        .pcpi_rd    (pcpi_rd),
        .pcpi_wait  (pcpi_wait),
        .pcpi_ready (pcpi_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [2:0] f3);
        return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb_, ua, ub, p;
        sa  = {{32{a[31]}}, a};
        sb_ = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        case (f3[1:0])
            2'b00:   begin p = sa * sb_; return p[31:0];  end
            2'b01:   begin p = sa * sb_; return p[63:32]; end
            2'b10:   begin p = sa * ub;  return p[63:32]; end
            default: begin p = ua * ub;  return p[63:32]; end
        endcase
    endfunction

    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input string name);
        int lat;
        bit got;
        logic [31:0] exp;
        sb.push_back(model(f3, a, b));
        @(posedge clk); #1;
        pcpi_valid = 1'b1; pcpi_insn = enc(f3); pcpi_rs1 = a; pcpi_rs2 = b;
        lat = 0; got = 0;
        while (!got && lat < 20) begin
            @(negedge clk); lat++;
            if (lat == 2) begin
                tests++;
                if (pcpi_wait !== 1'b0) begin fails++; $display("FAIL %s wait_early got=%b exp=0", name, pcpi_wait); end
                pcpi_rs1 = $urandom; pcpi_rs2 = $urandom; pcpi_insn = enc(f3 ^ 3'b011);
            end
            if (lat == 3) begin
                tests++;
                if (pcpi_wait !== 1'b1) begin fails++; $display("FAIL %s wait_rise got=%b exp=1", name, pcpi_wait); end
            end
            if (pcpi_ready === 1'b1) got = 1;
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL %s timeout got=no_ready exp=ready", name);
            if (sb.size() > 0) void'(sb.pop_front());
        end else begin
            exp = sb.pop_front();
            if (pcpi_rd !== exp || pcpi_wr !== 1'b1 || pcpi_wait !== 1'b0 || lat != 7) begin
                fails++;
                $display("FAIL %s rd=%h exp=%h wr=%b wait=%b lat=%0d exp_lat=7", name, pcpi_rd, exp, pcpi_wr, pcpi_wait, lat);
            end
        end
        repeat (hold) begin
            @(negedge clk);
            tests++;
            if (pcpi_ready !== 1'b0 || pcpi_wr !== 1'b0 || pcpi_wait !== 1'b0) begin
                fails++;
                $display("FAIL %s hold_reaccept ready=%b wr=%b wait=%b exp=0", name, pcpi_ready, pcpi_wr, pcpi_wait);
            end
        end
        pcpi_valid = 1'b0;
        if (hold == 0) begin
            @(negedge clk);
            tests++;
            if (pcpi_ready !== 1'b0 || pcpi_wr !== 1'b0) begin
                fails++;
                $display("FAIL %s one_pulse ready=%b wr=%b exp=0", name, pcpi_ready, pcpi_wr);
            end
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0; pcpi_valid = 1'b0; pcpi_insn = '0; pcpi_rs1 = '0; pcpi_rs2 = '0;
        repeat (3) @(negedge clk);
        tests++;
        if ({pcpi_wr, pcpi_ready, pcpi_wait} !== 3'b000 || pcpi_rd !== 32'd0) begin
            fails++;
            $display("FAIL reset_state rd=%h wr=%b ready=%b wait=%b exp=0", pcpi_rd, pcpi_wr, pcpi_ready, pcpi_wait);
        end
        resetn = 1'b1;
        @(negedge clk);
        tests++;
        if ({pcpi_wr, pcpi_ready, pcpi_wait} !== 3'b000 || pcpi_rd !== 32'd0) begin
            fails++;
            $display("FAIL reset_release rd=%h wr=%b ready=%b wait=%b exp=0", pcpi_rd, pcpi_wr, pcpi_ready, pcpi_wait);
        end
    endtask

    task automatic test_directed;
        do_op(3'b000, 32'd7,        32'hFFFFFFFD, 0, "mul_7xm3");
        do_op(3'b001, 32'h80000000, 32'h80000000, 0, "mulh_min");
        do_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "mulhu_max");
        do_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "mulhsu_m1");
        do_op(3'b010, 32'd0,        32'h12345678, 0, "mulhsu_zero");
        do_op(3'b001, 32'hFFFFFFFF, 32'd1,        0, "mulh_m1x1");
        do_op(3'b000, 32'h80000000, 32'hFFFFFFFF, 0, "mul_minxm1");
    endtask

    task automatic test_non_m;
        bit bad = 0;
        @(posedge clk); #1;
        pcpi_valid = 1'b1; pcpi_insn = 32'h00B50533; pcpi_rs1 = 32'd3; pcpi_rs2 = 32'd4;
        repeat (20) begin
            @(negedge clk);
            if (pcpi_wait !== 1'b0 || pcpi_ready !== 1'b0 || pcpi_wr !== 1'b0) bad = 1;
        end
        tests++;
        if (bad) begin fails++; $display("FAIL non_m_insn got=handshake exp=silent"); end
        pcpi_valid = 1'b0;
    endtask

    task automatic test_hold_valid;
        do_op(3'b011, 32'hDEADBEEF, 32'h00010001, 3, "hold_valid");
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++)
            do_op(3'($urandom_range(0, 3)), $urandom, $urandom, 0, "back_to_back");
    endtask

    task automatic test_abort;
        bit bad = 0;
        @(posedge clk); #1;
        pcpi_valid = 1'b1; pcpi_insn = enc(3'b001); pcpi_rs1 = 32'h11111111; pcpi_rs2 = 32'h22222222;
        repeat (3) @(negedge clk);
        pcpi_valid = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (pcpi_ready !== 1'b0 || pcpi_wr !== 1'b0) bad = 1;
        end
        tests++;
        if (bad || pcpi_wait !== 1'b0) begin
            fails++;
            $display("FAIL abort got=ready_or_wait wait=%b exp=idle", pcpi_wait);
        end
    endtask

    task automatic test_reset_mid;
        bit bad = 0;
        @(posedge clk); #1;
        pcpi_valid = 1'b1; pcpi_insn = enc(3'b011); pcpi_rs1 = 32'hFFFFFFFF; pcpi_rs2 = 32'hFFFFFFFF;
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        #1;
        tests++;
        if ({pcpi_wr, pcpi_ready, pcpi_wait} !== 3'b000 || pcpi_rd !== 32'd0) begin
            fails++;
            $display("FAIL reset_mid rd=%h wr=%b ready=%b wait=%b exp=0", pcpi_rd, pcpi_wr, pcpi_ready, pcpi_wait);
        end
        pcpi_valid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (pcpi_ready !== 1'b0 || pcpi_wr !== 1'b0 || pcpi_wait !== 1'b0) bad = 1;
        end
        tests++;
        if (bad) begin fails++; $display("FAIL reset_stale got=activity exp=idle"); end
        do_op(3'b000, 32'd12, 32'd13, 0, "after_reset");
    endtask

    initial begin
        test_reset;
        test_directed;
        test_non_m;
        test_hold_valid;
        test_back_to_back;
        test_abort;
        test_reset_mid;
        tests++;
        if (sb.size() != 0) begin fails++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
